// File: rtl/pipe_hazard_seq.sv
// Pipeline hazard sequencer: resolves data-cache, branch, instruction-cache and
// load-use hazards into stage enables, flushes and NOP injection.
module pipe_hazard_seq #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  dec_regA,
    input  logic [4:0]  dec_regB,
    input  logic        dec_usesA,
    input  logic        dec_usesB,
    input  logic        ex_mem_r_en,
    input  logic [4:0]  ex_regD,
    input  logic        branch_taken,
    input  logic        block_pipe_instr_cache,
    input  logic        block_pipe_data_cache,
    output logic        EN_REG_FETCH,
    output logic        EN_REG_DECODE,
    output logic        EN_REG_ALU,
    output logic        EN_REG_MEM,
    output logic        flush_decode,
    output logic        flush_alu,
    output logic        injecting_nop,
    output logic [31:0] inject_nop,
    output logic [2:0]  seq_state,
    output logic [31:0] stall_cycles
);

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        DSTALL = 3'd1,
        ISTALL = 3'd2,
        LSTALL = 3'd3,
        BFLUSH = 3'd4
    } state_t;

    state_t      state, next_state;
    logic        branch_pend, branch_pend_next;
    logic [31:0] stall_cnt;
    logic        load_use, load_use_eff, branch_eff;

    // A branch that arrives while the data cache freezes the pipe is remembered
    // here so it still flushes once the freeze lifts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            branch_pend <= 1'b0;
        end else begin
            state       <= next_state;
            branch_pend <= branch_pend_next;
        end
    end

    assign load_use = ex_mem_r_en && (ex_regD != 5'd0) &&
                      ((dec_usesA && (dec_regA == ex_regD)) ||
                       (dec_usesB && (dec_regB == ex_regD)));
    assign load_use_eff = load_use && (state != LSTALL);
    assign branch_eff   = branch_taken || branch_pend;

    always_comb begin
        next_state       = RUN;
        branch_pend_next = 1'b0;
        if (block_pipe_data_cache) begin
            next_state       = DSTALL;
            branch_pend_next = branch_eff;
        end else if (branch_eff) begin
            next_state = BFLUSH;
        end else if (block_pipe_instr_cache) begin
            next_state = ISTALL;
        end else if (load_use_eff) begin
            next_state = LSTALL;
        end
    end

    always_comb begin
        EN_REG_FETCH  = 1'b1;
        EN_REG_DECODE = 1'b1;
        EN_REG_ALU    = 1'b1;
        EN_REG_MEM    = 1'b1;
        flush_decode  = 1'b0;
        flush_alu     = 1'b0;
        injecting_nop = 1'b0;
        if (reset || block_pipe_data_cache) begin
            EN_REG_FETCH  = 1'b0;
            EN_REG_DECODE = 1'b0;
            EN_REG_ALU    = 1'b0;
            EN_REG_MEM    = 1'b0;
        end else begin
            if (branch_eff) begin
                flush_decode = 1'b1;
                flush_alu    = 1'b1;
            end else if (block_pipe_instr_cache || load_use_eff) begin
                EN_REG_FETCH  = 1'b0;
                injecting_nop = 1'b1;
            end
            // The word fetched down the wrong path is squashed after a flush.
            if (state == BFLUSH) begin
                injecting_nop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 32'd0;
        end else if (!EN_REG_FETCH && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt;
    assign seq_state    = state;
    assign inject_nop   = NOP_WORD;

endmodule

// File: tb/tb_pipe_hazard_seq.sv
// Self-checking bench for pipe_hazard_seq: vector table, corner sequences and
// a randomized run against a behavioural reference model.
module tb_pipe_hazard_seq;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int S_RUN = 0, S_DSTALL = 1, S_ISTALL = 2, S_LSTALL = 3, S_BFLUSH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  dec_regA, dec_regB, ex_regD;
    logic        dec_usesA, dec_usesB, ex_mem_r_en, branch_taken;
    logic        block_pipe_instr_cache, block_pipe_data_cache;
    logic        EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM;
    logic        flush_decode, flush_alu, injecting_nop;
    logic [31:0] inject_nop, stall_cycles;
    logic [2:0]  seq_state;

    int compared = 0;
    int mismatched = 0;

    pipe_hazard_seq #(.NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset),
        .dec_regA(dec_regA), .dec_regB(dec_regB),
        .dec_usesA(dec_usesA), .dec_usesB(dec_usesB),
        .ex_mem_r_en(ex_mem_r_en), .ex_regD(ex_regD),
        .branch_taken(branch_taken),
        .block_pipe_instr_cache(block_pipe_instr_cache),
        .block_pipe_data_cache(block_pipe_data_cache),
        .EN_REG_FETCH(EN_REG_FETCH), .EN_REG_DECODE(EN_REG_DECODE),
        .EN_REG_ALU(EN_REG_ALU), .EN_REG_MEM(EN_REG_MEM),
        .flush_decode(flush_decode), .flush_alu(flush_alu),
        .injecting_nop(injecting_nop), .inject_nop(inject_nop),
        .seq_state(seq_state), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  ra, rb;
        logic        ua, ub, mr;
        logic [4:0]  rd;
        logic        br, ic, dc;
        logic [3:0]  en;
        logic        fd, fa, nop;
        logic [2:0]  st;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic [4:0] ra, logic [4:0] rb, logic ua, logic ub,
                                logic mr, logic [4:0] rd, logic br, logic ic, logic dc,
                                logic [3:0] en, logic fd, logic fa, logic nop,
                                logic [2:0] st, logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.ra = ra; v.rb = rb; v.ua = ua; v.ub = ub; v.mr = mr; v.rd = rd;
        v.br = br; v.ic = ic; v.dc = dc; v.en = en; v.fd = fd; v.fa = fa; v.nop = nop;
        v.st = st; v.cnt = cnt;
        return v;
    endfunction

    function automatic vec_t stim(logic rst, logic br, logic ic, logic dc);
        return mk(rst, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, br, ic, dc,
                  4'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        reset = v.rst;
        dec_regA = v.ra; dec_regB = v.rb; dec_usesA = v.ua; dec_usesB = v.ub;
        ex_mem_r_en = v.mr; ex_regD = v.rd; branch_taken = v.br;
        block_pipe_instr_cache = v.ic; block_pipe_data_cache = v.dc;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM,
                flush_decode, flush_alu, injecting_nop};
    endfunction

    // Reference model state: current sequencer mode, deferred branch, stall count.
    int      m_state;
    bit      m_pend;
    longint  m_cnt;

    task automatic modelStep(input vec_t v, output logic [6:0] exp);
        bit lu, br;
        int ns;
        if (v.rst) begin
            exp = 7'b0;
            m_state = S_RUN; m_pend = 0; m_cnt = 0;
            return;
        end
        lu = v.mr && (v.rd != 0) && ((v.ua && v.ra == v.rd) || (v.ub && v.rb == v.rd))
             && (m_state != S_LSTALL);
        br = v.br || m_pend;
        if (v.dc) begin
            exp = 7'b0000_000; ns = S_DSTALL; m_pend = br;
        end else begin
            m_pend = 0;
            if (br)              begin exp = 7'b1111_110; ns = S_BFLUSH; end
            else if (v.ic)       begin exp = 7'b0111_001; ns = S_ISTALL; end
            else if (lu)         begin exp = 7'b0111_001; ns = S_LSTALL; end
            else                 begin exp = 7'b1111_000; ns = S_RUN;    end
            if (m_state == S_BFLUSH) exp[0] = 1'b1;
        end
        if (!exp[6]) m_cnt = (m_cnt + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt + 1;
        m_state = ns;
    endtask

    initial begin
        vec_t v;
        logic [6:0] exp;

        vecs.push_back(mk(1, 0,0,0,0,0,0, 0,0,0, 4'b0000,0,0,0, 0,0));
        vecs.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 4'b1111,0,0,0, 0,0));
        vecs.push_back(mk(0, 0,5,0,1,1,5, 0,0,0, 4'b0111,0,0,1, 0,0));
        vecs.push_back(mk(0, 0,5,0,1,1,5, 0,0,0, 4'b1111,0,0,0, 3,1));
        vecs.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 4'b1111,0,0,0, 0,1));
        vecs.push_back(mk(0, 0,0,1,0,1,0, 0,0,0, 4'b1111,0,0,0, 0,1));
        vecs.push_back(mk(0, 5,9,0,1,1,5, 0,0,0, 4'b1111,0,0,0, 0,1));
        vecs.push_back(mk(0, 0,0,0,0,0,0, 0,1,0, 4'b0111,0,0,1, 0,1));
        vecs.push_back(mk(0, 0,0,0,0,0,0, 0,1,0, 4'b0111,0,0,1, 2,2));
        vecs.push_back(mk(0, 0,0,0,0,0,0, 0,1,0, 4'b0111,0,0,1, 2,3));
        vecs.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 4'b1111,0,0,0, 2,4));
        vecs.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 4'b1111,0,0,0, 0,4));
        vecs.push_back(mk(0, 7,0,1,0,1,7, 0,1,0, 4'b0111,0,0,1, 0,4));
        vecs.push_back(mk(0, 0,0,0,0,0,0, 1,1,0, 4'b1111,1,1,0, 2,5));
        vecs.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 4'b1111,0,0,1, 4,5));
        vecs.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 4'b1111,0,0,0, 0,5));
        vecs.push_back(mk(0, 7,0,1,0,1,7, 0,0,0, 4'b0111,0,0,1, 0,5));
        vecs.push_back(mk(0, 0,0,0,0,0,0, 0,0,1, 4'b0000,0,0,0, 3,6));
        vecs.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 4'b1111,0,0,0, 1,7));
        vecs.push_back(mk(0, 0,0,0,0,0,0, 0,0,0, 4'b1111,0,0,0, 0,7));

        // Vector table
        applyStimulus(stim(1, 0, 0, 0));
        checkOutput("inject_nop_word", 64'(inject_nop), 64'(NOP));
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_outs", i), 64'(outs()),
                        64'({vecs[i].en, vecs[i].fd, vecs[i].fa, vecs[i].nop}));
            checkOutput($sformatf("vec%0d_state", i), 64'(seq_state), 64'(vecs[i].st));
            checkOutput($sformatf("vec%0d_stall", i), 64'(stall_cycles), 64'(vecs[i].cnt));
        end

        // Data-cache block with a coincident branch: branch deferred until the drop
        applyStimulus(stim(1, 0, 0, 0));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(stim(0, 1, 0, 1));
            checkOutput($sformatf("dc_br_frozen%0d", i), 64'(outs()), 64'(7'b0000_000));
        end
        applyStimulus(stim(0, 0, 0, 0));
        checkOutput("dc_br_flush", 64'(outs()), 64'(7'b1111_110));
        checkOutput("dc_br_stall", 64'(stall_cycles), 64'd4);
        applyStimulus(stim(0, 0, 0, 0));
        checkOutput("dc_br_bflush_outs", 64'(outs()), 64'(7'b1111_001));
        checkOutput("dc_br_bflush_state", 64'(seq_state), 64'(S_BFLUSH));
        applyStimulus(stim(0, 0, 0, 0));
        checkOutput("dc_br_after", 64'(outs()), 64'(7'b1111_000));

        // Reset asserted in the middle of an instruction-cache stall
        applyStimulus(stim(1, 0, 0, 0));
        applyStimulus(stim(0, 0, 1, 0));
        applyStimulus(stim(0, 0, 1, 0));
        checkOutput("istall_state", 64'(seq_state), 64'(S_ISTALL));
        applyStimulus(stim(1, 0, 1, 0));
        checkOutput("rst_mid_outs", 64'(outs()), 64'(7'b0000_000));
        applyStimulus(stim(1, 0, 0, 0));
        checkOutput("rst_hold_outs", 64'(outs()), 64'(7'b0000_000));
        applyStimulus(stim(0, 0, 0, 0));
        checkOutput("rst_rel_state", 64'(seq_state), 64'(S_RUN));
        checkOutput("rst_rel_stall", 64'(stall_cycles), 64'd0);
        checkOutput("rst_rel_outs", 64'(outs()), 64'(7'b1111_000));

        // Stall counter saturation from a preloaded value
        applyStimulus(stim(0, 0, 0, 0));
        force dut.stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(stim(0, 0, 1, 0));
            if (i > 0) checkOutput($sformatf("sat_cnt%0d", i), 64'(stall_cycles), 64'hFFFF_FFFF);
        end
        applyStimulus(stim(0, 0, 0, 0));
        checkOutput("sat_final", 64'(stall_cycles), 64'hFFFF_FFFF);

        // Randomized run against the reference model
        applyStimulus(stim(1, 0, 0, 0));
        modelStep(stim(1, 0, 0, 0), exp);
        for (int c = 0; c < 600; c++) begin
            v = mk(($urandom_range(39) == 0),
                   5'($urandom_range(3)), 5'($urandom_range(3)),
                   1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(3)),
                   ($urandom_range(7) == 0), ($urandom_range(5) == 0), ($urandom_range(7) == 0),
                   4'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
            applyStimulus(v);
            checkOutput($sformatf("rnd%0d_state", c), 64'(seq_state), 64'(m_state));
            checkOutput($sformatf("rnd%0d_stall", c), 64'(stall_cycles), 64'(m_cnt));
            modelStep(v, exp);
            checkOutput($sformatf("rnd%0d_outs", c), 64'(outs()), 64'(exp));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_seq.md
PIPE_HAZARD_SEQ -- requirements
Module: pipe_hazard_seq

Interface
REQ-001 SHALL use the parameter NOP_WORD, default 32'h0000_0000, as the instruction encoding driven on inject_nop.
REQ-002 SHALL have the port clk  input  1  clock; all state updates occur on the rising edge.
REQ-003 SHALL have the port reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have the ports dec_regA, dec_regB  input  5 each  source register numbers of the instruction in decode.
REQ-005 SHALL have the ports dec_usesA, dec_usesB  input  1 each  the decode instruction reads regA / regB.
REQ-006 SHALL have the ports ex_mem_r_en  input  1  and ex_regD  input  5  load flag and destination register of the instruction in the ALU stage.
REQ-007 SHALL have the port branch_taken  input  1  branch resolved as taken in the ALU stage.
REQ-008 SHALL have the ports block_pipe_instr_cache and block_pipe_data_cache  input  1 each  instruction-cache and data-cache miss in progress.
REQ-009 SHALL have the ports EN_REG_FETCH, EN_REG_DECODE, EN_REG_ALU, EN_REG_MEM  output  1 each  stage-register enables.
REQ-010 SHALL have the ports flush_decode and flush_alu  output  1 each  synchronous clear of the decode and ALU stage registers.
REQ-011 SHALL have the ports injecting_nop  output  1  and inject_nop  output  32  NOP select and the NOP word (constant NOP_WORD).
REQ-012 SHALL have the port seq_state  output  3  registered state: RUN=0, DSTALL=1, ISTALL=2, LSTALL=3, BFLUSH=4.
REQ-013 SHALL have the port stall_cycles  output  32  count of fetch-stalled cycles.

Function
REQ-014 SHALL compute all enable, flush and NOP outputs combinationally from the current inputs and seq_state, with zero-cycle latency.
REQ-015 SHALL detect load-use as ex_mem_r_en & (ex_regD!=0) & ((dec_usesA & dec_regA==ex_regD) | (dec_usesB & dec_regB==ex_regD)); register 0 never hazards.
REQ-016 SHALL apply cause priority, highest first: data-cache block, branch_taken, instruction-cache block, load-use, none.
REQ-017 SHALL, on a data-cache block, drive all four enables to 0, both flushes to 0 and injecting_nop to 0, and set next state DSTALL; a coincident branch_taken is deferred, not lost.
REQ-018 SHALL, on branch_taken without a data-cache block, drive all enables to 1 and flush_decode=flush_alu=1 for that cycle, and set next state BFLUSH.
REQ-019 SHALL, in state BFLUSH, drive injecting_nop=1 and all enables to 1 for exactly one cycle, squashing the wrong-path fetch word; higher-priority causes still apply.
REQ-020 SHALL, on an instruction-cache block (no higher cause), drive EN_REG_FETCH=0, EN_REG_DECODE=EN_REG_ALU=EN_REG_MEM=1 and injecting_nop=1, and set next state ISTALL.
REQ-021 SHALL, on load-use (no higher cause), drive EN_REG_FETCH=0, the other enables 1 and injecting_nop=1, and set next state LSTALL.
REQ-022 SHALL, in LSTALL, ignore load-use for one cycle so that each hazard inserts exactly one bubble; other causes are still evaluated.
REQ-023 SHALL, with no cause, drive all enables to 1, flushes 0 and injecting_nop 0, with next state RUN.
REQ-024 SHALL increment stall_cycles on every non-reset cycle in which EN_REG_FETCH=0, saturating at 32'hFFFF_FFFF.
REQ-025 SHALL drive inject_nop as the constant NOP_WORD at all times.

Reset
REQ-026 SHALL, while reset=1, drive all enables 0, flushes 0 and injecting_nop 0.
REQ-027 SHALL, on a reset edge, set seq_state to RUN and stall_cycles to 0.
REQ-028 SHALL abandon any in-progress stall on a reset asserted mid-operation, with no residual bubble after release.

Verification
REQ-029 SHALL be verified by: ex_mem_r_en=1, ex_regD=5, dec_regB=5, dec_usesB=1 -> one cycle FETCH=0, injecting_nop=1; next cycle RUN outputs; stall_cycles=1.
REQ-030 SHALL be verified by: same hazard with ex_regD=0 -> no stall, stall_cycles stays 0.
REQ-031 SHALL be verified by: block_pipe_data_cache high for 4 cycles with branch_taken=1 -> 4 cycles all EN=0 and flushes 0; the cycle after the drop has flush_decode=flush_alu=1, then one BFLUSH cycle with injecting_nop=1.
REQ-032 SHALL be verified by: block_pipe_instr_cache high for 3 cycles -> FETCH=0, DECODE/ALU/MEM=1, injecting_nop=1 for 3 cycles; stall_cycles=3.
REQ-033 SHALL be verified by: reset asserted during ISTALL -> enables 0 while reset is high; after release seq_state=0 and stall_cycles=0.
REQ-034 SHALL be verified by: stall_cycles preloaded (forced) to 32'hFFFF_FFFE followed by 3 stalled cycles -> value holds at 32'hFFFF_FFFF.
